// File: rtl/team_06_keyctrl_gen_pkg.sv
// Shared types and button indices for the keypad controller.
package team_06_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    TALK   = 2'd2,
    MUTED  = 2'd3
  } mode_t;

  localparam int BTN_PTT    = 0;
  localparam int BTN_MUTE   = 1;
  localparam int BTN_EFFECT = 2;
  localparam int BTN_NG     = 3;

endpackage

// File: rtl/team_06_keyctrl_gen_if.sv
// Control/status bundle between the keypad controller and its surroundings.
interface team_06_keyctrl_gen_if #(
  parameter int NUM_BTN = 4,
  parameter int VOL_W   = 2,
  parameter int AUD_W   = 8,
  parameter int EFF_W   = 3
);
  logic [NUM_BTN-1:0] pbs;
  logic [VOL_W-1:0]   vol;
  logic [AUD_W-1:0]   mic_aud;
  logic [AUD_W-1:0]   spk_aud;
  logic [1:0]         state;
  logic               vol_en;
  logic [EFF_W-1:0]   current_effect;
  logic               mute_tog;
  logic               noise_gate_tog;
  logic               tx_open;

  modport master (
    output pbs, vol, mic_aud, spk_aud,
    input  state, vol_en, current_effect, mute_tog, noise_gate_tog, tx_open
  );

  modport slave (
    input  pbs, vol, mic_aud, spk_aud,
    output state, vol_en, current_effect, mute_tog, noise_gate_tog, tx_open
  );
endinterface

// File: rtl/team_06_keyctrl_gen_debounce.sv
// One-button synchroniser + debouncer with a single-cycle press pulse.
module team_06_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic level,
  output logic press
);
  logic       sync_a;
  logic       sync_b;
  logic [7:0] cnt;

  // The level flips on the cycle after DEB_CYCLES differing samples have been counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_a <= pb;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (cnt == 8'(DEB_CYCLES)) begin
        level <= ~level;
        press <= ~level;
        cnt   <= '0;
      end else if (sync_b != level) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/team_06_keyctrl_gen.sv
// Push-to-talk keypad controller: debounced buttons, effect selector,
// mute/noise-gate latches and a speaker hang timer driving the mode FSM.
//   state  | meaning
//   IDLE   | no traffic, speaker stage off
//   LISTEN | speaker activity or hang timer still running
//   TALK   | PTT held, transmit path may open
//   MUTED  | mute latched, overrides all other modes
module team_06_keyctrl_gen
  import team_06_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int DEB_CYCLES  = 4,
  parameter int NUM_EFFECTS = 6,
  parameter int AUD_W       = 8,
  parameter int VOL_W       = 2,
  parameter int ACT_THRESH  = 16,
  parameter int HANG_CYCLES = 8
) (
  input logic clk,
  input logic rst,
  team_06_keyctrl_gen_if.slave bus
);
  localparam int EFF_W  = $clog2(NUM_EFFECTS);
  localparam int HANG_W = $clog2(HANG_CYCLES + 1);
  localparam logic [AUD_W:0] MID = (AUD_W+1)'(1) << (AUD_W - 1);

  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] press;
  logic               unused_btn;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    team_06_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .pb    (bus.pbs[i]),
      .level (deb[i]),
      .press (press[i])
    );
  end

  assign unused_btn = ^{deb, press};

  // Magnitude is formed one bit wider than the sample so 0 and full-scale cannot wrap.
  function automatic logic is_active(input logic [AUD_W-1:0] s);
    logic [AUD_W:0] ext;
    logic [AUD_W:0] mag;
    ext = {1'b0, s};
    mag = (ext >= MID) ? (ext - MID) : (MID - ext);
    return mag >= (AUD_W+1)'(ACT_THRESH);
  endfunction

  logic spk_act;
  logic mic_act;
  assign spk_act = is_active(bus.spk_aud);
  assign mic_act = is_active(bus.mic_aud);

  mode_t             state_q;
  mode_t             state_nx;
  logic [HANG_W-1:0] hang;
  logic [EFF_W-1:0]  eff_q;
  logic              mute_q;
  logic              ng_q;
  logic              vol_en_q;
  logic              tx_q;

  always_comb begin
    state_nx = IDLE;
    if (mute_q)                        state_nx = MUTED;
    else if (deb[BTN_PTT])             state_nx = TALK;
    else if (spk_act || hang != '0)    state_nx = LISTEN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hang     <= '0;
      eff_q    <= '0;
      mute_q   <= 1'b0;
      ng_q     <= 1'b0;
      vol_en_q <= 1'b0;
      tx_q     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      vol_en_q <= (state_nx == LISTEN) && (bus.vol != '0);
      tx_q     <= (state_nx == TALK) && (!ng_q || mic_act);

      if (state_q == TALK || state_q == MUTED) hang <= '0;
      else if (spk_act)                       hang <= HANG_W'(HANG_CYCLES);
      else if (hang != '0)                    hang <= hang - 1'b1;

      if (press[BTN_MUTE]) mute_q <= ~mute_q;
      if (press[BTN_NG])   ng_q   <= ~ng_q;
      if (press[BTN_EFFECT]) begin
        if (eff_q == EFF_W'(NUM_EFFECTS - 1)) eff_q <= '0;
        else                                  eff_q <= eff_q + 1'b1;
      end
    end
  end

  assign bus.state          = state_q;
  assign bus.vol_en         = vol_en_q;
  assign bus.current_effect = eff_q;
  assign bus.mute_tog       = mute_q;
  assign bus.noise_gate_tog = ng_q;
  assign bus.tx_open        = tx_q;
endmodule
